pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
- Control and output stage wrapped around the free-running period counter.
- Drives the counter's period input and a counter-restart strobe, and consumes the counter's count value to produce a PWM waveform.
- Takes period/duty updates through a valid/ready handshake into a shadow register. Updates become active only on a counter wrap, so output cycles are never torn.
- Start and stop are aligned to wrap boundaries.

Parameters:
- WIDTH, 32, width of count, period and duty.
- DEFAULT_PERIOD, 1000, period_out value after reset (must be >= 1).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- count_in  input  WIDTH  count from the counter, 0..period_out-1
- cfg_valid_in  input  1  new configuration offered
- cfg_ready_out  output  1  shadow register free; the offer is accepted when valid and ready are both high
- cfg_period_in  input  WIDTH  requested period in cycles
- cfg_duty_in  input  WIDTH  requested high-time in cycles
- enable_in  input  1  level request to run PWM
- period_out  output  WIDTH  active period, wired to the counter's period input
- count_rst_out  output  1  one-cycle strobe, ORed into the counter's reset
- pwm_out  output  1  PWM waveform
- wrap_out  output  1  one-cycle pulse per completed period
- busy_out  output  1  high in every state other than IDLE

Behaviour:
- Reset values (applied on the rst_in clock edge): period_out=DEFAULT_PERIOD, active duty=0, shadow empty, cfg_ready_out=1, pwm_out=0, wrap_out=0, count_rst_out=0, busy_out=0, state=IDLE.
- wrap (internal, combinational) = (count_in == period_out-1). Compare at full WIDTH.
- wrap_out is registered: it is high the cycle after wrap.
- Handshake:
  - cfg_ready_out = !pending.
  - On acceptance, cfg_period_in is stored in the shadow register, except that 0 is stored as 1. cfg_duty_in is stored unchanged, and pending is set.
  - Payload is ignored when valid=0.
  - Valid may drop without acceptance.
- Applying the shadow:
  - In RUN, ARMED or STOPPING: the shadow is applied on a clock edge where wrap=1 and pending=1. The active period/duty load and pending clears, so the new values take effect from count 0.
  - A config accepted in the same cycle as wrap is not bypassed; it applies at the next wrap.
  - In IDLE: a pending shadow is applied on the next edge, with count_rst_out=1 for that one cycle so the counter restarts at 0 under the new period.
- PWM output:
  - pwm_out is registered: pwm_out <= (state==RUN) && (count_in < active_duty). This gives 1-cycle latency from count_in.
  - Duty 0 gives a constant low output.
  - Duty >= period gives a constant high output for the whole period.
- States:
  - IDLE: enable_in=1 -> ARMED.
  - ARMED: wrap=1 -> RUN, so the first high pwm_out cycle corresponds to count 0. enable_in=0 -> IDLE.
  - RUN: enable_in=0 -> STOPPING.
  - STOPPING: keeps generating PWM (pwm_out follows the RUN formula). On wrap -> IDLE. enable_in=1 before the wrap -> RUN with no gap.
  - Where both exits of a state apply in the same cycle, enable_in takes priority.
- Reset mid-operation:
  - Returns all state to the reset values on the next edge.
  - Discards any pending shadow.
  - Any cfg offer present during reset is not accepted.

Test Plan:
- Reset, then hold enable_in=0 -> period_out=1000, pwm_out=0, cfg_ready_out=1, busy_out=0.
- In IDLE, send cfg period=10, duty=3 -> cfg_ready_out falls for 1 cycle; the next edge sets period_out=10 and count_rst_out=1 for 1 cycle; the counter restarts at 0.
- Raise enable_in with period=10, duty=3 -> pwm_out high for exactly 3 of every 10 cycles, rising 1 cycle after count_in=0. wrap_out pulses once per 10 cycles.
- In RUN at count 4, send period=8, duty=8 -> cfg_ready_out stays 0 until the wrap; the old 10/3 pattern completes; the following period is 8 cycles with pwm_out constantly high.
- Send cfg period=0, duty=0 -> period_out becomes 1; pwm_out stays 0; wrap_out is high every cycle once the config is active.
- In RUN, drop enable_in at count 2 -> the current period finishes, then IDLE and pwm_out=0. Repeat, but re-raise enable_in at count 5 -> no missed pulse. Assert rst_in mid-period with a config pending -> everything returns to reset values and the pending config is discarded.

Source files
------------

// File: rtl/pwm_ctrl.sv
// PWM control stage around a free-running period counter.
// Owns the active period/duty, a one-deep shadow register loaded through a
// valid/ready handshake, and the run/stop state machine. New settings and
// start/stop take effect only on counter wrap boundaries.
module pwm_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 1000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             cfg_valid_in,
  output logic             cfg_ready_out,
  input  logic [WIDTH-1:0] cfg_period_in,
  input  logic [WIDTH-1:0] cfg_duty_in,
  input  logic             enable_in,
  output logic [WIDTH-1:0] period_out,
  output logic             count_rst_out,
  output logic             pwm_out,
  output logic             wrap_out,
  output logic             busy_out
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] shadow_period;
  logic [WIDTH-1:0] shadow_duty;
  logic             pending;
  logic             wrap;
  logic             accept;
  logic             apply;
  logic             gen_active;

  // A zero period would never wrap; the smallest legal period is one cycle.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
    return (p == '0) ? ONE : p;
  endfunction

  assign wrap          = (count_in == (period_out - ONE));
  assign cfg_ready_out = !pending;
  assign accept        = cfg_valid_in && !pending && !rst_in;
  // Idle has no cycle to tear, so a pending shadow goes live at once.
  assign apply         = pending && ((state == IDLE) || wrap);
  assign gen_active    = (state == RUN) || (state == STOPPING);

  // Shadow payload capture; only meaningful while pending is set.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      shadow_period <= clamp_period(cfg_period_in);
      shadow_duty   <= cfg_duty_in;
    end
  end

  // Control state, active settings and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      period_out    <= RST_PERIOD;
      active_duty   <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      wrap_out      <= 1'b0;
      count_rst_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      wrap_out      <= wrap;
      pwm_out       <= gen_active && (count_in < active_duty);
      count_rst_out <= pending && (state == IDLE);

      if (apply) begin
        period_out  <= shadow_period;
        active_duty <= shadow_duty;
        pending     <= 1'b0;
      end else if (accept) begin
        pending     <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable_in) begin
            state    <= ARMED;
            busy_out <= 1'b1;
          end
        end
        ARMED: begin
          if (!enable_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (wrap) begin
            state    <= RUN;
          end
        end
        RUN: begin
          if (!enable_in) begin
            state <= STOPPING;
          end
        end
        STOPPING: begin
          if (enable_in) begin
            state    <= RUN;
          end else if (wrap) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed bench for pwm_ctrl. The bench plays the role of the period
// counter by driving count_in explicitly each cycle.
module tb_pwm_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] count_in;
  logic        cfg_valid_in;
  logic        cfg_ready_out;
  logic [31:0] cfg_period_in;
  logic [31:0] cfg_duty_in;
  logic        enable_in;
  logic [31:0] period_out;
  logic        count_rst_out;
  logic        pwm_out;
  logic        wrap_out;
  logic        busy_out;

  int tests = 0;
  int fails = 0;

  pwm_ctrl #(.WIDTH(32), .DEFAULT_PERIOD(1000)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .count_in      (count_in),
    .cfg_valid_in  (cfg_valid_in),
    .cfg_ready_out (cfg_ready_out),
    .cfg_period_in (cfg_period_in),
    .cfg_duty_in   (cfg_duty_in),
    .enable_in     (enable_in),
    .period_out    (period_out),
    .count_rst_out (count_rst_out),
    .pwm_out       (pwm_out),
    .wrap_out      (wrap_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic [31:0] cp;
    logic [31:0] cd;
    logic [31:0] cnt;
    logic [31:0] e_per;
    logic        e_pwm;
    logic        e_wrp;
    logic        e_crst;
    logic        e_rdy;
    logic        e_bsy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic [31:0] cnt, input logic en, input logic vld,
                      input logic [31:0] cp, input logic [31:0] cd);
    count_in      = cnt;
    enable_in     = en;
    cfg_valid_in  = vld;
    cfg_period_in = cp;
    cfg_duty_in   = cd;
    @(posedge clk_in);
    #1;
  endtask

  // One full counter period while enabled, checking the waveform.
  task automatic run_period(input int per, input int duty, input string tag);
    for (int c = 0; c < per; c++) begin
      step(c, 1'b1, 1'b0, 0, 0);
      chk($sformatf("%s pwm c=%0d", tag, c), pwm_out, (c < duty) ? 1 : 0);
      chk($sformatf("%s wrap c=%0d", tag, c), wrap_out, (c == per - 1) ? 1 : 0);
      chk($sformatf("%s busy c=%0d", tag, c), busy_out, 1);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    count_in = 0;
    cfg_valid_in = 0;
    cfg_period_in = 0;
    cfg_duty_in = 0;
    enable_in = 0;

    //          rst en vld cp  cd  cnt   per  pwm wrp crst rdy bsy
    vecs[0]  = '{1'b1, 0, 0,  0,  0,  0, 1000, 0, 0, 0, 1, 0};
    vecs[1]  = '{1'b0, 0, 0,  0,  0,  5, 1000, 0, 0, 0, 1, 0};
    vecs[2]  = '{1'b0, 0, 1, 10,  3,  6, 1000, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 0, 0,  0,  0,  7,   10, 0, 0, 1, 1, 0};
    vecs[4]  = '{1'b0, 0, 0, 55, 55,  8,   10, 0, 0, 0, 1, 0};
    vecs[5]  = '{1'b0, 1, 0,  0,  0,  0,   10, 0, 0, 0, 1, 1};
    vecs[6]  = '{1'b0, 0, 0,  0,  0,  1,   10, 0, 0, 0, 1, 0};
    vecs[7]  = '{1'b0, 1, 0,  0,  0,  2,   10, 0, 0, 0, 1, 1};
    vecs[8]  = '{1'b0, 1, 0,  0,  0,  9,   10, 0, 1, 0, 1, 1};
    vecs[9]  = '{1'b0, 1, 0,  0,  0,  0,   10, 1, 0, 0, 1, 1};
    vecs[10] = '{1'b0, 1, 0,  0,  0,  1,   10, 1, 0, 0, 1, 1};
    vecs[11] = '{1'b0, 1, 0,  0,  0,  2,   10, 1, 0, 0, 1, 1};
    vecs[12] = '{1'b0, 1, 0,  0,  0,  3,   10, 0, 0, 0, 1, 1};
    vecs[13] = '{1'b0, 1, 0,  0,  0,  9,   10, 0, 1, 0, 1, 1};

    @(negedge clk_in);
    for (int i = 0; i < 14; i++) begin
      rst_in = vecs[i].rst;
      step(vecs[i].cnt, vecs[i].en, vecs[i].vld, vecs[i].cp, vecs[i].cd);
      chk($sformatf("vec%0d period", i), period_out,    vecs[i].e_per);
      chk($sformatf("vec%0d pwm", i),    pwm_out,       vecs[i].e_pwm);
      chk($sformatf("vec%0d wrap", i),   wrap_out,      vecs[i].e_wrp);
      chk($sformatf("vec%0d cnt_rst", i), count_rst_out, vecs[i].e_crst);
      chk($sformatf("vec%0d ready", i),  cfg_ready_out, vecs[i].e_rdy);
      chk($sformatf("vec%0d busy", i),   busy_out,      vecs[i].e_bsy);
    end

    // Steady 10/3 waveform.
    run_period(10, 3, "run10");
    run_period(10, 3, "run10b");

    // Mid-period reconfiguration to 8/8: old period completes, then constant high.
    for (int c = 0; c < 4; c++) begin
      step(c, 1, 0, 0, 0);
      chk("recfg pre pwm", pwm_out, (c < 3) ? 1 : 0);
    end
    step(4, 1, 1, 8, 8);
    chk("recfg accept ready", cfg_ready_out, 0);
    for (int c = 5; c < 10; c++) begin
      step(c, 1, 0, 0, 0);
      chk($sformatf("recfg hold ready c=%0d", c), cfg_ready_out, (c == 9) ? 1 : 0);
      chk($sformatf("recfg period c=%0d", c), period_out, (c == 9) ? 8 : 10);
      chk($sformatf("recfg old pwm c=%0d", c), pwm_out, 0);
    end
    run_period(8, 8, "full8");
    chk("full8 period", period_out, 8);

    // Period 0 is clamped to 1; duty 0 gives constant low, wrap every cycle.
    step(0, 1, 1, 0, 0);
    chk("p0 accept ready", cfg_ready_out, 0);
    chk("p0 accept pwm", pwm_out, 1);
    for (int c = 1; c < 8; c++) begin
      step(c, 1, 0, 0, 0);
      chk("p0 tail pwm", pwm_out, 1);
    end
    chk("p0 period", period_out, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0);
      chk("p1 pwm low", pwm_out, 0);
      chk("p1 wrap", wrap_out, 1);
      chk("p1 period", period_out, 1);
    end
    step(0, 1, 1, 10, 3);
    chk("back accept ready", cfg_ready_out, 0);
    chk("back accept period", period_out, 1);
    step(0, 1, 0, 0, 0);
    chk("back apply period", period_out, 10);
    chk("back apply ready", cfg_ready_out, 1);
    chk("back apply pwm", pwm_out, 0);
    run_period(10, 3, "back10");

    // Stop at count 2: period finishes, then idle.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int c = 2; c < 10; c++) begin
      step(c, 0, 0, 0, 0);
      chk($sformatf("stop pwm c=%0d", c), pwm_out, (c < 3) ? 1 : 0);
      chk($sformatf("stop busy c=%0d", c), busy_out, (c == 9) ? 0 : 1);
    end
    for (int c = 0; c < 4; c++) begin
      step(c, 0, 0, 0, 0);
      chk("idle pwm", pwm_out, 0);
      chk("idle busy", busy_out, 0);
    end
    step(4, 1, 0, 0, 0);
    chk("rearm busy", busy_out, 1);
    for (int c = 5; c < 10; c++) begin
      step(c, 1, 0, 0, 0);
      chk("armed pwm", pwm_out, 0);
    end
    run_period(10, 3, "restart");

    // Stop at 2, re-enable at 5: no gap in the next period.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int c = 2; c < 10; c++) begin
      step(c, (c >= 5), 0, 0, 0);
      chk($sformatf("resume pwm c=%0d", c), pwm_out, (c < 3) ? 1 : 0);
      chk($sformatf("resume busy c=%0d", c), busy_out, 1);
    end
    run_period(10, 3, "resumed");

    // Reset mid-period with a pending config and an offer during reset.
    for (int c = 0; c < 4; c++) step(c, 1, 0, 0, 0);
    step(4, 1, 1, 5, 2);
    chk("rst pend ready", cfg_ready_out, 0);
    rst_in = 1'b1;
    step(5, 1, 1, 7, 1);
    rst_in = 1'b0;
    chk("rst period", period_out, 1000);
    chk("rst pwm", pwm_out, 0);
    chk("rst wrap", wrap_out, 0);
    chk("rst cnt_rst", count_rst_out, 0);
    chk("rst ready", cfg_ready_out, 1);
    chk("rst busy", busy_out, 0);
    for (int c = 6; c < 8; c++) begin
      step(c, 0, 0, 0, 0);
      chk("post rst period", period_out, 1000);
      chk("post rst cnt_rst", count_rst_out, 0);
      chk("post rst ready", cfg_ready_out, 1);
      chk("post rst busy", busy_out, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
